// File: rtl/dram_ctrl.sv
// Single-word DRAM controller: takes one bus request at a time and sequences
// PRE/ACT/READ/WRITE on the DRAM pins with programmable gaps, keeping the last row open.
module dram_ctrl #(
  parameter int T_RCD      = 5,
  parameter int T_RP       = 5,
  parameter int T_WR       = 5,
  parameter int RD_TIMEOUT = 64
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_strb,
  input  logic [20:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic        DRAM_valid,
  input  logic [31:0] DRAM_Q
);
  localparam int MAX_AB = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int MAX_CD = (T_WR > RD_TIMEOUT) ? T_WR : RD_TIMEOUT;
  localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_T) + 1;

  // Counters hold (cycles - 1); the last wait cycle is the one with cnt == 0.
  // The read timeout loads one less because its response leaves through a register.
  localparam logic [CW-1:0] RP_LOAD  = CW'(T_RP - 1);
  localparam logic [CW-1:0] RCD_LOAD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] WR_LOAD  = CW'(T_WR - 1);
  localparam logic [CW-1:0] RD_LOAD  = CW'(RD_TIMEOUT - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_RW, S_RD_WAIT, S_WR_WAIT
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          row_open;
  logic [10:0]   open_row;
  logic          we_q;
  logic [3:0]    strb_q;
  logic [20:0]   addr_q;
  logic [31:0]   wdata_q;

  logic          handshake;
  logic          cur_we;
  logic [3:0]    cur_strb;
  logic [20:0]   cur_addr;
  logic [31:0]   cur_wdata;

  logic          ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0]   rsp_rdata_d;
  logic          csn_d, rasn_d, casn_d;
  logic [3:0]    wen_d;
  logic [10:0]   a_d;
  logic [31:0]   d_d;

  assign handshake = req_valid && req_ready;

  // Commands leave the IDLE state in the same edge the request is latched.
  assign cur_we    = (state == S_IDLE) ? req_we    : we_q;
  assign cur_strb  = (state == S_IDLE) ? req_strb  : strb_q;
  assign cur_addr  = (state == S_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == S_IDLE) ? req_wdata : wdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      row_open <= 1'b0;
      open_row <= '0;
      we_q     <= 1'b0;
      strb_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        case (state_next)
          S_PRE_WAIT: cnt <= RP_LOAD;
          S_ACT_WAIT: cnt <= RCD_LOAD;
          S_RD_WAIT:  cnt <= RD_LOAD;
          S_WR_WAIT:  cnt <= WR_LOAD;
          default:    cnt <= '0;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
      if (state_next == S_ACT) begin
        row_open <= 1'b1;
        open_row <= cur_addr[20:10];
      end
      if (handshake) begin
        we_q    <= req_we;
        strb_q  <= req_strb;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (handshake) begin
          if (!row_open)                          state_next = S_ACT;
          else if (req_addr[20:10] == open_row)   state_next = S_RW;
          else                                    state_next = S_PRE;
        end
      end
      S_PRE:      state_next = S_PRE_WAIT;
      S_PRE_WAIT: if (cnt == '0) state_next = S_ACT;
      S_ACT:      state_next = S_ACT_WAIT;
      S_ACT_WAIT: if (cnt == '0) state_next = S_RW;
      S_RW:       state_next = we_q ? S_WR_WAIT : S_RD_WAIT;
      S_RD_WAIT:  if (DRAM_valid || cnt == '0) state_next = S_IDLE;
      S_WR_WAIT:  if (cnt == '0) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Pin values are decoded from the state being entered, so each command is
  // visible on the pins for exactly the one cycle its state lasts.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    ready_d     = (state == S_IDLE) && (state_next == S_IDLE);
    csn_d       = 1'b1;
    rasn_d      = 1'b1;
    casn_d      = 1'b1;
    wen_d       = 4'hF;
    a_d         = DRAM_A;
    d_d         = DRAM_D;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state_next)
      S_PRE: begin
        csn_d  = 1'b0;
        rasn_d = 1'b0;
        wen_d  = 4'h0;
      end
      S_ACT: begin
        csn_d  = 1'b0;
        rasn_d = 1'b0;
        a_d    = cur_addr[20:10];
      end
      S_RW: begin
        csn_d  = 1'b0;
        casn_d = 1'b0;
        a_d    = {1'b0, cur_addr[9:0]};
        if (cur_we) begin
          wen_d = ~cur_strb;
          d_d   = cur_wdata;
        end
      end
      default: ;
    endcase
    if (state == S_RD_WAIT && DRAM_valid) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = DRAM_Q;
      rsp_err_d   = 1'b0;
    end else if (state == S_RD_WAIT && cnt == '0) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end else if (state == S_WR_WAIT && cnt == '0) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      DRAM_CSn  <= 1'b1;
      DRAM_RASn <= 1'b1;
      DRAM_CASn <= 1'b1;
      DRAM_WEn  <= 4'hF;
      DRAM_A    <= '0;
      DRAM_D    <= '0;
    end else begin
      req_ready <= ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      DRAM_CSn  <= csn_d;
      DRAM_RASn <= rasn_d;
      DRAM_CASn <= casn_d;
      DRAM_WEn  <= wen_d;
      DRAM_A    <= a_d;
      DRAM_D    <= d_d;
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: a pin-level DRAM model answers reads, a transaction-level
// model predicts data, open-row behaviour and command timing.
module tb_dram_ctrl;
  localparam int T_RCD      = 5;
  localparam int T_RP       = 5;
  localparam int T_WR       = 5;
  localparam int RD_TIMEOUT = 64;
  localparam int LAT        = 2;

  typedef enum int {K_ACT, K_RD, K_WR, K_PRE, K_BAD} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [10:0] a;
    logic [3:0]  wen;
    logic [31:0] d;
  } cmd_t;
  typedef struct {
    bit          we;
    logic [20:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_pre;
    bit          exp_act;
  } vec_t;

  logic        cpu_clk, cpu_rst;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_strb;
  logic [20:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;
  logic        DRAM_valid;
  logic [31:0] DRAM_Q;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  cmd_t        log_q[$];
  logic [31:0] dmem    [logic [20:0]];
  logic [31:0] ref_mem [logic [20:0]];
  bit          model_open;
  logic [10:0] model_row;
  bit          drop_rd;
  int          pend;
  logic [20:0] pend_key;
  logic [10:0] drow;

  dram_ctrl #(.T_RCD(T_RCD), .T_RP(T_RP), .T_WR(T_WR), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_strb(req_strb),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn), .DRAM_WEn(DRAM_WEn),
    .DRAM_A(DRAM_A), .DRAM_D(DRAM_D), .DRAM_valid(DRAM_valid), .DRAM_Q(DRAM_Q)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  initial forever begin
    @(posedge cpu_clk);
    cyc++;
  end

  function automatic logic [31:0] dflt(input logic [20:0] k);
    return ({11'h0, k} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dram_rd(input logic [20:0] k);
    return dmem.exists(k) ? dmem[k] : dflt(k);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [20:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
  endfunction

  function automatic logic [63:0] pack(input cmd_t c, input bit use_a, input bit use_d);
    return {c.cyc[13:0], c.kind[2:0], use_a ? c.a : 11'h0, c.wen, use_d ? c.d : 32'h0};
  endfunction

  function automatic int count_kind(input int from, input kind_t k);
    int n;
    n = 0;
    for (int i = from; i < log_q.size(); i++) if (log_q[i].kind == k) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // DRAM pin model: decodes commands mid-cycle, stores writes by (open row, column)
  // and answers each READ LAT cycles later unless drop_rd is set.
  initial begin
    DRAM_valid = 1'b0;
    DRAM_Q     = '0;
    pend       = 0;
    drow       = '0;
    forever begin
      @(negedge cpu_clk);
      DRAM_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !drop_rd) begin
          DRAM_valid = 1'b1;
          DRAM_Q     = dram_rd(pend_key);
        end
      end
      if (DRAM_CSn == 1'b0) begin
        cmd_t c;
        c.cyc = cyc;
        c.a   = DRAM_A;
        c.wen = DRAM_WEn;
        c.d   = DRAM_D;
        if (!DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF) begin
          c.kind = K_ACT;
          drow   = DRAM_A;
        end else if (!DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'h0) begin
          c.kind = K_PRE;
        end else if (DRAM_RASn && !DRAM_CASn && DRAM_WEn == 4'hF) begin
          c.kind   = K_RD;
          pend     = LAT;
          pend_key = {drow, DRAM_A[9:0]};
        end else if (DRAM_RASn && !DRAM_CASn) begin
          c.kind = K_WR;
          dmem[{drow, DRAM_A[9:0]}] = merge(dram_rd({drow, DRAM_A[9:0]}), DRAM_D, ~DRAM_WEn);
        end else begin
          c.kind = K_BAD;
        end
        log_q.push_back(c);
      end
    end
  end

  task automatic chk_cmd(input string name, input int idx, input cmd_t e,
                         input bit use_a, input bit use_d);
    check({name, "_present"}, 64'(log_q.size() > idx), 64'(1));
    if (log_q.size() > idx) check(name, pack(log_q[idx], use_a, use_d), pack(e, use_a, use_d));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ctl"},
          64'({req_ready, rsp_valid, rsp_err, DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A}),
          64'({3'b000, 3'b111, 4'hF, 11'h0}));
    check({tag, "_data"}, 64'({rsp_rdata, DRAM_D}), 64'(0));
  endtask

  // One complete transaction, checked against the open-row model and the timing rules.
  task automatic do_req(input bit we, input logic [20:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input bit drop,
                        output logic [31:0] rdata, output int n_pre, output int n_act);
    bit exp_pre, exp_act;
    int h, r, t, idx, idx0, n;
    cmd_t e;
    exp_pre = model_open && (model_row != addr[20:10]);
    exp_act = !model_open || exp_pre;
    drop_rd   = drop;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_strb  = strb;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge cpu_clk); #1; n++; end
    check("req_ready_wait", 64'(req_ready), 64'(1));
    h = cyc;
    idx0 = log_q.size();
    idx = idx0;
    @(posedge cpu_clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < RD_TIMEOUT + 100) begin @(posedge cpu_clk); #1; n++; end
    check("rsp_wait", 64'(rsp_valid), 64'(1));
    r = cyc;
    rdata = rsp_rdata;
    t = h + 1;
    e.d = '0;
    if (exp_pre) begin
      e.cyc = t; e.kind = K_PRE; e.a = '0; e.wen = 4'h0;
      chk_cmd("pre", idx, e, 1'b0, 1'b0);
      idx++; t += T_RP + 1;
    end
    if (exp_act) begin
      e.cyc = t; e.kind = K_ACT; e.a = addr[20:10]; e.wen = 4'hF;
      chk_cmd("act", idx, e, 1'b1, 1'b0);
      idx++; t += T_RCD + 1;
    end
    e.cyc  = t;
    e.kind = (we && strb != 4'h0) ? K_WR : K_RD;
    e.a    = {1'b0, addr[9:0]};
    e.wen  = we ? ~strb : 4'hF;
    e.d    = wdata;
    chk_cmd(we ? "write" : "read", idx, e, 1'b1, we);
    idx++;
    check("cmd_count", 64'(log_q.size() - idx0), 64'(idx - idx0));
    check("rsp_cycle", 64'(r), 64'(t + (we ? T_WR + 1 : (drop ? RD_TIMEOUT : LAT + 1))));
    check("rsp_err", 64'(rsp_err), 64'(!we && drop));
    if (!we) check("rsp_rdata", 64'(rsp_rdata), 64'(drop ? 32'h0 : ref_rd(addr)));
    n_pre = count_kind(idx0, K_PRE);
    n_act = count_kind(idx0, K_ACT);
    @(posedge cpu_clk); #1;
    check("rsp_pulse", 64'(rsp_valid), 64'(0));
    check("ready_after_rsp", 64'(req_ready), 64'(1));
    if (we) ref_mem[addr] = merge(ref_rd(addr), wdata, strb);
    model_open = 1'b1;
    model_row  = addr[20:10];
  endtask

  initial begin
    vec_t        vt[8];
    logic [10:0] rows[3];
    logic [31:0] rd;
    logic [20:0] addr;
    int          npre, nact, idx0, n_rdy, n_rsp;

    vt[0] = '{1'b0, 21'h040000, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    vt[1] = '{1'b1, 21'h040001, 4'h5, 32'h11223344, 32'h0,        1'b0, 1'b0};
    vt[2] = '{1'b0, 21'h040001, 4'h0, 32'h0,        32'hAA22CC44, 1'b0, 1'b0};
    vt[3] = '{1'b0, 21'h040400, 4'h0, 32'h0,        32'hCAFEF00D, 1'b1, 1'b1};
    vt[4] = '{1'b1, 21'h040400, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0};
    vt[5] = '{1'b0, 21'h040400, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0};
    vt[6] = '{1'b1, 21'h040000, 4'hF, 32'h12345678, 32'h0,        1'b1, 1'b1};
    vt[7] = '{1'b0, 21'h040000, 4'h0, 32'h0,        32'h12345678, 1'b0, 1'b0};

    dmem[21'h040000] = 32'hDEADBEEF;  ref_mem[21'h040000] = 32'hDEADBEEF;
    dmem[21'h040001] = 32'hAABBCCDD;  ref_mem[21'h040001] = 32'hAABBCCDD;
    dmem[21'h040400] = 32'hCAFEF00D;  ref_mem[21'h040400] = 32'hCAFEF00D;

    cpu_rst   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_strb  = '0;
    req_addr  = '0;
    req_wdata = '0;
    drop_rd   = 1'b0;
    model_open = 1'b0;
    model_row  = '0;
    #12;
    chk_reset("reset");
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    @(posedge cpu_clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_req(vt[i].we, vt[i].addr, vt[i].strb, vt[i].wdata, 1'b0, rd, npre, nact);
      if (!vt[i].we) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vt[i].exp_rdata));
      check($sformatf("vec%0d_pre_act", i), 64'({npre[1:0], nact[1:0]}),
            64'({1'b0, vt[i].exp_pre, 1'b0, vt[i].exp_act}));
    end

    // Read that never sees DRAM_valid: forced error response.
    do_req(1'b0, 21'h040002, 4'h0, 32'h0, 1'b1, rd, npre, nact);
    drop_rd = 1'b0;

    // Four same-row reads with req_valid held high.
    addr = {11'h155, 10'h3};
    idx0 = log_q.size();
    n_rdy = 0;
    n_rsp = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    for (int n = 0; n < 400; n++) begin
      if (req_ready) n_rdy++;
      if (rsp_valid) begin
        n_rsp++;
        check($sformatf("b2b_rdata%0d", n_rsp), 64'(rsp_rdata), 64'(ref_rd(addr)));
      end
      if (n_rsp == 4) break;
      @(posedge cpu_clk); #1;
    end
    req_valid = 1'b0;
    check("b2b_ready_pulses", 64'(n_rdy), 64'(4));
    check("b2b_rsp_pulses", 64'(n_rsp), 64'(4));
    check("b2b_act_count", 64'(count_kind(idx0, K_ACT)), 64'(1));
    model_open = 1'b1;
    model_row  = 11'h155;
    @(posedge cpu_clk); #1;

    rows[0] = 11'h100;
    rows[1] = 11'h101;
    rows[2] = 11'h155;
    for (int i = 0; i < 40; i++) begin
      addr = {rows[$urandom_range(0, 2)], 10'($urandom_range(0, 3))};
      do_req(1'($urandom_range(0, 1)), addr, 4'($urandom), $urandom, 1'b0, rd, npre, nact);
    end

    // Reset while waiting out tRCD, then the same row must be activated again.
    addr = {11'h2AA, 10'h5};
    idx0 = log_q.size();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    for (int n = 0; n < 50 && !req_ready; n++) begin @(posedge cpu_clk); #1; end
    @(posedge cpu_clk); #1;
    req_valid = 1'b0;
    for (int n = 0; n < 50 && count_kind(idx0, K_ACT) == 0; n++) begin @(posedge cpu_clk); #1; end
    check("rst_act_issued", 64'(count_kind(idx0, K_ACT)), 64'(1));
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;
    #1;
    chk_reset("midop_reset");
    model_open = 1'b0;
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    repeat (3) @(posedge cpu_clk);
    #1;
    check("rst_no_cas", 64'(count_kind(idx0, K_RD) + count_kind(idx0, K_WR)), 64'(0));
    do_req(1'b0, addr, 4'h0, 32'h0, 1'b0, rd, npre, nact);
    check("rst_reactivate", 64'({npre[1:0], nact[1:0]}), 64'({2'd0, 2'd1}));

    check("illegal_cmds", 64'(count_kind(0, K_BAD)), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 2000000", $time);
    $fatal(1);
  end

endmodule
